rc2014_io_regs: RTL and testbench

Parametrised RC2014 I/O-port register bank for the FPGA bus interface. Decodes Z80 I/O writes and reads to a block of NUM_PORTS consecutive port addresses starting at BASE_ADDR. Latches written bytes and returns register contents on reads, with bus-direction control. Drives a stretched activity LED that can retrigger. Successor to the single fixed-port write-detect LED logic.

---
 rtl/rc2014_io_regs.sv | 123 ++++++++++++
 tb/tb_rc2014_io_regs.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rc2014_io_regs.sv
// RC2014 I/O-port register bank: synchronised Z80 bus decode, NUM_PORTS byte
// registers with write strobes, read-back with bus direction, stretched activity LED.
module rc2014_io_regs #(
    parameter logic [7:0] BASE_ADDR   = 8'hC0,
    parameter int         NUM_PORTS   = 4,
    parameter int         PORT_BITS   = 2,
    parameter int         SYNC_STAGES = 2,
    parameter int         LED_BITS    = 21,
    parameter int         RETRIGGER   = 0,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [7:0]             A,
    input  logic [7:0]             D_IN,
    output logic [7:0]             D_OUT,
    output logic                   D_OE,
    output logic                   DATA_DIR,
    input  logic                   IORQ,
    input  logic                   RD,
    input  logic                   WR,
    input  logic                   M1,
    input  logic                   BUT1,
    output logic [8*NUM_PORTS-1:0] REGS,
    output logic [NUM_PORTS-1:0]   WR_STB,
    output logic                   LED1
);

    localparam logic [PORT_BITS:0] NP = NUM_PORTS[PORT_BITS:0];

    logic [7:0] a_sq   [SYNC_STAGES];
    logic [7:0] d_sq   [SYNC_STAGES];
    logic [4:0] ctl_sq [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] settle_q;

    logic [NUM_PORTS-1:0][7:0] regs_q, regs_d;
    logic [NUM_PORTS-1:0]      stb_q, stb_d;
    logic [7:0]                dout_q, dout_d;
    logic                      doe_q, doe_d;
    logic                      wr_prev_q;
    logic                      blk_q, blk_d;
    logic [LED_BITS-1:0]       cnt_q, cnt_d;

    logic [7:0]           a_s, d_s;
    logic                 iorq_s, rd_s, wr_s, m1_s, but_s;
    logic [PORT_BITS-1:0] idx;
    logic                 hit, settled, wr_act, rd_act, wr_ev, led_ev;

    assign a_s     = a_sq[SYNC_STAGES-1];
    assign d_s     = d_sq[SYNC_STAGES-1];
    assign {iorq_s, rd_s, wr_s, m1_s, but_s} = ctl_sq[SYNC_STAGES-1];
    assign settled = settle_q[SYNC_STAGES-1];
    assign idx     = a_s[PORT_BITS-1:0];
    assign hit     = (a_s[7:PORT_BITS] == BASE_ADDR[7:PORT_BITS]) && ({1'b0, idx} < NP);

    // blk_q suppresses any bus cycle that was already in progress when reset released
    assign wr_act = !iorq_s && !wr_s && m1_s && hit && !blk_q;
    assign rd_act = !iorq_s && !rd_s && wr_s && m1_s && hit && !blk_q;
    assign wr_ev  = wr_act && !wr_prev_q;
    assign led_ev = wr_ev || !but_s;

    always_comb begin
        regs_d = regs_q;
        stb_d  = '0;
        if (wr_ev) begin
            regs_d[idx] = d_s;
            stb_d[idx]  = 1'b1;
        end
        doe_d  = rd_act;
        dout_d = rd_act ? regs_q[idx] : dout_q;
        blk_d  = blk_q;
        if (settled && (iorq_s || (rd_s && wr_s)))
            blk_d = 1'b0;
        cnt_d = cnt_q;
        if (led_ev && ((RETRIGGER != 0) || (cnt_q == '0)))
            cnt_d = '1;
        else if (cnt_q != '0)
            cnt_d = cnt_q - LED_BITS'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                a_sq[i]   <= '0;
                d_sq[i]   <= '0;
                ctl_sq[i] <= '1;
            end
            settle_q  <= '0;
            regs_q    <= {NUM_PORTS{RESET_VAL}};
            stb_q     <= '0;
            dout_q    <= '0;
            doe_q     <= 1'b0;
            wr_prev_q <= 1'b0;
            blk_q     <= 1'b1;
            cnt_q     <= '0;
        end else begin
            a_sq[0]   <= A;
            d_sq[0]   <= D_IN;
            ctl_sq[0] <= {IORQ, RD, WR, M1, BUT1};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sq[i]   <= a_sq[i-1];
                d_sq[i]   <= d_sq[i-1];
                ctl_sq[i] <= ctl_sq[i-1];
            end
            settle_q  <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            regs_q    <= regs_d;
            stb_q     <= stb_d;
            dout_q    <= dout_d;
            doe_q     <= doe_d;
            wr_prev_q <= wr_act;
            blk_q     <= blk_d;
            cnt_q     <= cnt_d;
        end
    end

    assign REGS     = regs_q;
    assign WR_STB   = stb_q;
    assign D_OUT    = dout_q;
    assign D_OE     = doe_q;
    assign DATA_DIR = doe_q;
    assign LED1     = (cnt_q != '0);

endmodule

// File: tb/tb_rc2014_io_regs.sv
// Directed bench for rc2014_io_regs: one DUT without LED retrigger, one with.
module tb_rc2014_io_regs;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST;
    logic [7:0] A, D_IN;
    logic       IORQ, RD, WR, M1, BUT1;

    logic [7:0]  dout0, dout1;
    logic        doe0, doe1, dir0, dir1, led0, led1;
    logic [31:0] regs0, regs1;
    logic [3:0]  stb0, stb1;

    int tests = 0;
    int fails = 0;

    rc2014_io_regs #(.BASE_ADDR(8'hC0), .NUM_PORTS(4), .PORT_BITS(2), .SYNC_STAGES(2),
                     .LED_BITS(4), .RETRIGGER(0), .RESET_VAL(8'h00)) u_dut0 (
        .CLK(CLK), .RST(RST), .A(A), .D_IN(D_IN), .D_OUT(dout0), .D_OE(doe0),
        .DATA_DIR(dir0), .IORQ(IORQ), .RD(RD), .WR(WR), .M1(M1), .BUT1(BUT1),
        .REGS(regs0), .WR_STB(stb0), .LED1(led0));

    rc2014_io_regs #(.BASE_ADDR(8'hC0), .NUM_PORTS(4), .PORT_BITS(2), .SYNC_STAGES(2),
                     .LED_BITS(4), .RETRIGGER(1), .RESET_VAL(8'h00)) u_dut1 (
        .CLK(CLK), .RST(RST), .A(A), .D_IN(D_IN), .D_OUT(dout1), .D_OE(doe1),
        .DATA_DIR(dir1), .IORQ(IORQ), .RD(RD), .WR(WR), .M1(M1), .BUT1(BUT1),
        .REGS(regs1), .WR_STB(stb1), .LED1(led1));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic bus_idle();
        IORQ = 1'b1; RD = 1'b1; WR = 1'b1; M1 = 1'b1; A = 8'h00; D_IN = 8'h00;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        tick(2);
        RST = 1'b1;
        tick(3);
        tests++; if (regs0 !== 32'h0) begin fails++; $display("FAIL reset_regs: got %h want %h", regs0, 32'h0); end
        tests++; if (stb0 !== 4'h0) begin fails++; $display("FAIL reset_stb: got %b want %b", stb0, 4'h0); end
        tests++; if (doe0 !== 1'b0 || dir0 !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b/%b want 0/0", doe0, dir0); end
        tests++; if (dout0 !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h want 00", dout0); end
        tests++; if (led0 !== 1'b0 || led1 !== 1'b0) begin fails++; $display("FAIL reset_led: got %b/%b want 0/0", led0, led1); end
    endtask

    task automatic test_write();
        int n;
        A = 8'hC2; D_IN = 8'h5A; IORQ = 1'b0; WR = 1'b0;
        tick(2);
        tests++; if (stb0 !== 4'b0000 || regs0 !== 32'h0) begin fails++; $display("FAIL write_early: stb %b regs %h want 0000/0", stb0, regs0); end
        tick(1);
        tests++; if (stb0 !== 4'b0100 || stb1 !== 4'b0100) begin fails++; $display("FAIL write_stb: got %b/%b want 0100", stb0, stb1); end
        tests++; if (regs0 !== 32'h005A0000 || regs1 !== 32'h005A0000) begin fails++; $display("FAIL write_regs: got %h/%h want 005a0000", regs0, regs1); end
        n = led0 ? 1 : 0;
        bus_idle();
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (i == 0) begin
                tests++; if (stb0 !== 4'b0000) begin fails++; $display("FAIL write_stb_one_cycle: got %b want 0000", stb0); end
            end
            if (led0) n++;
            else break;
        end
        tests++; if (n !== 15) begin fails++; $display("FAIL write_led_len: got %0d want 15", n); end
    endtask

    task automatic test_held_write();
        int pulses = 0;
        A = 8'hC1; D_IN = 8'h33; IORQ = 1'b0; WR = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (stb0 != 4'b0000) begin
                pulses++;
                tests++; if (stb0 !== 4'b0010) begin fails++; $display("FAIL held_stb_bit: got %b want 0010", stb0); end
            end
        end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL held_pulses: got %0d want 1", pulses); end
        tests++; if (regs0 !== 32'h005A3300) begin fails++; $display("FAIL held_regs: got %h want 005a3300", regs0); end
        bus_idle();
        tick(24);
    endtask

    task automatic test_nonhit();
        int bad = 0;
        A = 8'hC4; D_IN = 8'h77; IORQ = 1'b0; WR = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (stb0 !== 4'b0000 || led0 !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL nonhit_stb_led: got %0d bad cycles want 0", bad); end
        tests++; if (regs0 !== 32'h005A3300) begin fails++; $display("FAIL nonhit_regs: got %h want 005a3300", regs0); end
        bus_idle();
        tick(4);
    endtask

    task automatic test_read();
        A = 8'hC2; IORQ = 1'b0; RD = 1'b0;
        tick(2);
        tests++; if (doe0 !== 1'b0) begin fails++; $display("FAIL read_oe_early: got %b want 0", doe0); end
        tick(1);
        tests++; if (doe0 !== 1'b1 || dir0 !== 1'b1 || doe1 !== 1'b1 || dir1 !== 1'b1) begin fails++; $display("FAIL read_oe: got %b%b%b%b want 1111", doe0, dir0, doe1, dir1); end
        tests++; if (dout0 !== 8'h5A || dout1 !== 8'h5A) begin fails++; $display("FAIL read_data: got %h/%h want 5a", dout0, dout1); end
        tick(2);
        RD = 1'b1; IORQ = 1'b1;
        tick(2);
        tests++; if (doe0 !== 1'b1) begin fails++; $display("FAIL read_oe_hold: got %b want 1", doe0); end
        tick(1);
        tests++; if (doe0 !== 1'b0 || dir0 !== 1'b0) begin fails++; $display("FAIL read_oe_release: got %b/%b want 0/0", doe0, dir0); end
        tests++; if (dout0 !== 8'h5A) begin fails++; $display("FAIL read_dout_hold: got %h want 5a", dout0); end
        bus_idle();
        tick(4);
        A = 8'hC1; IORQ = 1'b0; RD = 1'b0;
        tick(3);
        tests++; if (dout0 !== 8'h33 || doe0 !== 1'b1) begin fails++; $display("FAIL read_port1: got %h oe %b want 33 oe 1", dout0, doe0); end
        bus_idle();
        tick(4);
    endtask

    task automatic test_int_ack();
        int bad = 0;
        A = 8'hC2; IORQ = 1'b0; M1 = 1'b0; RD = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (doe0 !== 1'b0 || stb0 !== 4'b0000) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL intack_oe: got %0d bad cycles want 0", bad); end
        tests++; if (regs0 !== 32'h005A3300) begin fails++; $display("FAIL intack_regs: got %h want 005a3300", regs0); end
        bus_idle();
        tick(4);
    endtask

    task automatic test_rd_wr_both();
        int bad = 0;
        A = 8'hC3; D_IN = 8'h99; IORQ = 1'b0; RD = 1'b0; WR = 1'b0;
        tick(3);
        tests++; if (stb0 !== 4'b1000 || regs0 !== 32'h995A3300) begin fails++; $display("FAIL rdwr_write: stb %b regs %h want 1000/995a3300", stb0, regs0); end
        for (int i = 0; i < 5; i++) begin
            if (doe0 !== 1'b0) bad++;
            tick(1);
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL rdwr_oe: got %0d cycles driven want 0", bad); end
        bus_idle();
        tick(24);
    endtask

    task automatic test_retrigger();
        int off0 = -1;
        int off1 = -1;
        A = 8'hC0; D_IN = 8'h11; IORQ = 1'b0; WR = 1'b0;
        tick(3);
        tests++; if (stb0 !== 4'b0001 || led0 !== 1'b1 || led1 !== 1'b1) begin fails++; $display("FAIL retrig_first: stb %b led %b%b want 0001/11", stb0, led0, led1); end
        bus_idle();
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (!led0 && off0 < 0) off0 = k;
            if (!led1 && off1 < 0) off1 = k;
            if (k == 2) begin
                A = 8'hC1; D_IN = 8'h22; IORQ = 1'b0; WR = 1'b0;
            end
            if (k == 5) begin
                tests++; if (stb0 !== 4'b0010 || regs0 !== 32'h995A2211) begin fails++; $display("FAIL retrig_second: stb %b regs %h want 0010/995a2211", stb0, regs0); end
                bus_idle();
            end
        end
        tests++; if (off0 !== 15) begin fails++; $display("FAIL retrig0_off: got %0d want 15", off0); end
        tests++; if (off1 !== 20) begin fails++; $display("FAIL retrig1_off: got %0d want 20", off1); end
    endtask

    task automatic test_button();
        int on0 = 0;
        int on1 = 0;
        BUT1 = 1'b0;
        tick(3);
        for (int i = 0; i < 30; i++) begin
            if (i > 0) tick(1);
            if (led0) on0++;
            if (led1) on1++;
        end
        tests++; if (on1 !== 30) begin fails++; $display("FAIL button_retrig_on: got %0d want 30", on1); end
        tests++; if (on0 !== 29) begin fails++; $display("FAIL button_idle_reload: got %0d want 29", on0); end
        BUT1 = 1'b1;
        tick(25);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        A = 8'hC0; D_IN = 8'h44; IORQ = 1'b0; WR = 1'b0;
        tick(3);
        WR = 1'b1; A = 8'hC2; RD = 1'b0;
        tick(3);
        tests++; if (doe0 !== 1'b1 || led0 !== 1'b1 || regs0 !== 32'h995A2244) begin fails++; $display("FAIL rstmid_pre: oe %b led %b regs %h want 1/1/995a2244", doe0, led0, regs0); end
        RST = 1'b0;
        tick(1);
        tests++; if (led0 !== 1'b0 || led1 !== 1'b0) begin fails++; $display("FAIL rstmid_led: got %b/%b want 0/0", led0, led1); end
        tests++; if (regs0 !== 32'h0 || stb0 !== 4'b0000) begin fails++; $display("FAIL rstmid_regs: got %h/%b want 0/0000", regs0, stb0); end
        tests++; if (doe0 !== 1'b0 || dout0 !== 8'h00) begin fails++; $display("FAIL rstmid_oe: got %b/%h want 0/00", doe0, dout0); end
        RST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (doe0 !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL rstmid_stale_read: got %0d cycles driven want 0", bad); end
        bus_idle();
        tick(4);
        A = 8'hC2; IORQ = 1'b0; RD = 1'b0;
        tick(3);
        tests++; if (doe0 !== 1'b1 || dout0 !== 8'h00) begin fails++; $display("FAIL rstmid_reread: oe %b data %h want 1/00", doe0, dout0); end
        bus_idle();
        tick(4);
    endtask

    initial begin
        RST = 1'b0;
        BUT1 = 1'b1;
        bus_idle();
        test_reset();
        test_write();
        test_held_write();
        test_nonhit();
        test_read();
        test_int_ack();
        test_rd_wr_both();
        test_retrigger();
        test_button();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
